// File: rtl/prog_mem_ctrl_if.sv
// Bus bundle for the program RAM controller: debug/JTAG access port,
// user read ports and the RAM-side interface.
interface prog_mem_ctrl_if #(
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int MEM_DATA_WIDTH = 32,
    parameter int NUM_PORTS      = 2
);
    localparam int BE_W = MEM_DATA_WIDTH / 8;

    logic                                dbg_en;
    logic                                dbg_req;
    logic                                dbg_we;
    logic                                dbg_load;
    logic                                dbg_autoinc;
    logic [MEM_ADDR_WIDTH-1:0]           dbg_addr;
    logic [MEM_DATA_WIDTH-1:0]           dbg_wdata;
    logic [BE_W-1:0]                     dbg_be;
    logic [MEM_DATA_WIDTH-1:0]           dbg_rdata;
    logic                                dbg_ack;
    logic                                dbg_overrun;
    logic                                dbg_mode;
    logic                                cpu_rst_n;

    logic [NUM_PORTS-1:0]                usr_req;
    logic [NUM_PORTS*MEM_ADDR_WIDTH-1:0] usr_addr;
    logic [NUM_PORTS-1:0]                usr_gnt;
    logic [NUM_PORTS-1:0]                usr_valid;
    logic [NUM_PORTS*MEM_DATA_WIDTH-1:0] usr_rdata;

    logic                                mem_en;
    logic                                mem_we;
    logic [BE_W-1:0]                     mem_be;
    logic [MEM_ADDR_WIDTH-1:0]           mem_addr;
    logic [MEM_DATA_WIDTH-1:0]           mem_wdata;
    logic [MEM_DATA_WIDTH-1:0]           mem_rdata;

    modport slave (
        input  dbg_en, dbg_req, dbg_we, dbg_load, dbg_autoinc, dbg_addr, dbg_wdata, dbg_be,
        output dbg_rdata, dbg_ack, dbg_overrun, dbg_mode, cpu_rst_n,
        input  usr_req, usr_addr,
        output usr_gnt, usr_valid, usr_rdata,
        output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output dbg_en, dbg_req, dbg_we, dbg_load, dbg_autoinc, dbg_addr, dbg_wdata, dbg_be,
        input  dbg_rdata, dbg_ack, dbg_overrun, dbg_mode, cpu_rst_n,
        output usr_req, usr_addr,
        input  usr_gnt, usr_valid, usr_rdata,
        input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/prog_mem_ctrl.sv
// Program RAM controller: round-robin user read ports plus a debug/programming
// port that locks out users and holds the CPU in reset while active.
module prog_mem_ctrl #(
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int MEM_DATA_WIDTH = 32,
    parameter int NUM_PORTS      = 2
) (
    input logic           clk,
    input logic           rst,
    prog_mem_ctrl_if.slave bus
);
    localparam int AW = MEM_ADDR_WIDTH;
    localparam int DW = MEM_DATA_WIDTH;
    localparam int BW = MEM_DATA_WIDTH / 8;
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [2:0] {
        NORMAL,
        DRAIN,
        DBG_IDLE,
        DBG_WR,
        DBG_RD,
        DBG_RDW
    } state_t;

    state_t                  state_q, state_d;
    logic                    drain_cnt_q, drain_cnt_d;
    logic [PW-1:0]           prio_q, prio_d;
    logic [AW-1:0]           ptr_q, ptr_d;
    logic [AW-1:0]           acc_addr_q, acc_addr_d;
    logic [DW-1:0]           acc_wdata_q, acc_wdata_d;
    logic [BW-1:0]           acc_be_q, acc_be_d;
    logic                    dbg_ack_q, dbg_ack_d;
    logic [DW-1:0]           dbg_rdata_q, dbg_rdata_d;
    logic                    dbg_overrun_q, dbg_overrun_d;
    logic                    dbg_mode_q, dbg_mode_d;
    logic                    cpu_rst_n_q, cpu_rst_n_d;
    logic [NUM_PORTS-1:0]    rd_vld_p1_q, rd_vld_p1_d;
    logic [NUM_PORTS-1:0]    usr_valid_q, usr_valid_d;
    logic [NUM_PORTS*DW-1:0] usr_rdata_q, usr_rdata_d;

    logic [NUM_PORTS-1:0]    gnt;
    logic [AW-1:0]           gnt_addr;
    logic [AW-1:0]           dbg_acc_addr;

    // Round-robin search starting at prio_q; grants are held off during reset
    always_comb begin
        int   idx;
        logic found;
        idx      = 0;
        found    = 1'b0;
        gnt      = '0;
        gnt_addr = '0;
        prio_d   = prio_q;
        if (!rst && state_q == NORMAL) begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                idx = int'(prio_q) + k;
                if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
                if (!found && bus.usr_req[idx]) begin
                    found    = 1'b1;
                    gnt[idx] = 1'b1;
                    gnt_addr = bus.usr_addr[idx*AW +: AW];
                    prio_d   = (idx == NUM_PORTS - 1) ? '0 : PW'(idx + 1);
                end
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        drain_cnt_d   = drain_cnt_q;
        ptr_d         = ptr_q;
        acc_addr_d    = acc_addr_q;
        acc_wdata_d   = acc_wdata_q;
        acc_be_d      = acc_be_q;
        dbg_ack_d     = 1'b0;
        dbg_rdata_d   = dbg_rdata_q;
        dbg_overrun_d = dbg_overrun_q;
        dbg_acc_addr  = bus.dbg_autoinc ? (bus.dbg_load ? bus.dbg_addr : ptr_q) : bus.dbg_addr;

        if (bus.dbg_req && state_q != DBG_IDLE) dbg_overrun_d = 1'b1;

        unique case (state_q)
            NORMAL: begin
                if (bus.dbg_en) begin
                    state_d     = DRAIN;
                    drain_cnt_d = 1'b0;
                end
            end
            DRAIN: begin
                // Two cycles cover the grant issued in the cycle dbg_en rose
                drain_cnt_d = 1'b1;
                if (drain_cnt_q) state_d = DBG_IDLE;
            end
            DBG_IDLE: begin
                if (bus.dbg_req) begin
                    acc_addr_d  = dbg_acc_addr;
                    acc_wdata_d = bus.dbg_wdata;
                    acc_be_d    = bus.dbg_be;
                    if (bus.dbg_load)    ptr_d = bus.dbg_addr;
                    if (bus.dbg_autoinc) ptr_d = dbg_acc_addr + AW'(1);
                    state_d = bus.dbg_we ? DBG_WR : DBG_RD;
                end else if (!bus.dbg_en) begin
                    state_d = NORMAL;
                end
            end
            DBG_WR: begin
                dbg_ack_d = 1'b1;
                state_d   = DBG_IDLE;
            end
            DBG_RD: begin
                state_d = DBG_RDW;
            end
            DBG_RDW: begin
                dbg_ack_d   = 1'b1;
                dbg_rdata_d = bus.mem_rdata;
                state_d     = DBG_IDLE;
            end
            default: state_d = NORMAL;
        endcase

        dbg_mode_d  = (state_d != NORMAL);
        cpu_rst_n_d = (state_d == NORMAL);
    end

    always_comb begin
        rd_vld_p1_d = gnt;
        usr_valid_d = rd_vld_p1_q;
        usr_rdata_d = usr_rdata_q;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (rd_vld_p1_q[i]) usr_rdata_d[i*DW +: DW] = bus.mem_rdata;
        end
    end

    // RAM side; an access in flight when rst rises never reaches the RAM
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_be    = '0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (!rst) begin
            case (state_q)
                NORMAL: begin
                    bus.mem_en   = |gnt;
                    bus.mem_addr = gnt_addr;
                end
                DBG_WR: begin
                    bus.mem_en    = 1'b1;
                    bus.mem_we    = |acc_be_q;
                    bus.mem_be    = acc_be_q;
                    bus.mem_addr  = acc_addr_q;
                    bus.mem_wdata = acc_wdata_q;
                end
                DBG_RD: begin
                    bus.mem_en   = 1'b1;
                    bus.mem_addr = acc_addr_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= NORMAL;
            drain_cnt_q   <= 1'b0;
            prio_q        <= '0;
            ptr_q         <= '0;
            dbg_ack_q     <= 1'b0;
            dbg_rdata_q   <= '0;
            dbg_overrun_q <= 1'b0;
            dbg_mode_q    <= 1'b0;
            cpu_rst_n_q   <= 1'b0;
            rd_vld_p1_q   <= '0;
            usr_valid_q   <= '0;
            usr_rdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            drain_cnt_q   <= drain_cnt_d;
            prio_q        <= prio_d;
            ptr_q         <= ptr_d;
            dbg_ack_q     <= dbg_ack_d;
            dbg_rdata_q   <= dbg_rdata_d;
            dbg_overrun_q <= dbg_overrun_d;
            dbg_mode_q    <= dbg_mode_d;
            cpu_rst_n_q   <= cpu_rst_n_d;
            rd_vld_p1_q   <= rd_vld_p1_d;
            usr_valid_q   <= usr_valid_d;
            usr_rdata_q   <= usr_rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        acc_addr_q  <= acc_addr_d;
        acc_wdata_q <= acc_wdata_d;
        acc_be_q    <= acc_be_d;
    end

    assign bus.usr_gnt     = gnt;
    assign bus.usr_valid   = usr_valid_q;
    assign bus.usr_rdata   = usr_rdata_q;
    assign bus.dbg_ack     = dbg_ack_q;
    assign bus.dbg_rdata   = dbg_rdata_q;
    assign bus.dbg_overrun = dbg_overrun_q;
    assign bus.dbg_mode    = dbg_mode_q;
    assign bus.cpu_rst_n   = cpu_rst_n_q;
endmodule

// File: tb/tb_prog_mem_ctrl.sv
// Scoreboard bench for prog_mem_ctrl with a behavioural 1-cycle-latency RAM.
module tb_prog_mem_ctrl;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int NP = 2;

    localparam logic [31:0] VAL_A = 32'hA5A5_0005;
    localparam logic [31:0] VAL_B = 32'hB6B6_0009;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    prog_mem_ctrl_if #(.MEM_ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW), .NUM_PORTS(NP)) bus ();

    prog_mem_ctrl #(.MEM_ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW), .NUM_PORTS(NP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        int          port;
        logic [31:0] data;
        int          due;
    } usr_exp_t;

    typedef struct {
        logic        rd;
        logic [31:0] data;
        int          due;
    } dbg_exp_t;

    usr_exp_t usr_q[$];
    dbg_exp_t dbg_q[$];

    logic [31:0] ram [0:(1<<AW)-1];
    logic        ram_init_done = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (!ram_init_done) begin
            for (int i = 0; i < (1<<AW); i++) ram[i] <= 32'h0;
            ram[5]     <= VAL_A;
            ram[9]     <= VAL_B;
            ram[1]     <= 32'h0000_1111;
            ram[7]     <= 32'hDEAD_BEEF;
            ram[10'h20] <= 32'h1122_3344;
            ram[10'h30] <= 32'h5555_5555;
            ram_init_done <= 1'b1;
        end else if (bus.mem_en) begin
            if (bus.mem_we) begin
                for (int b = 0; b < DW/8; b++)
                    if (bus.mem_be[b]) ram[bus.mem_addr][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
            end
            bus.mem_rdata <= ram[bus.mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one debug strobe in the current cycle; queues the expected ack if it should be accepted
    task automatic dbg_go(input logic we, input logic load, input logic autoinc,
                          input logic [AW-1:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input logic [31:0] exp_rd, input bit expect_ack);
        dbg_exp_t e;
        if (expect_ack) begin
            e.rd   = !we;
            e.data = exp_rd;
            e.due  = cyc + (we ? 2 : 3);
            dbg_q.push_back(e);
        end
        bus.dbg_we      = we;
        bus.dbg_load    = load;
        bus.dbg_autoinc = autoinc;
        bus.dbg_addr    = addr;
        bus.dbg_wdata   = wdata;
        bus.dbg_be      = be;
        bus.dbg_req     = 1'b1;
        tick(1);
        bus.dbg_req     = 1'b0;
        bus.dbg_load    = 1'b0;
        bus.dbg_autoinc = 1'b0;
    endtask

    always @(negedge clk) begin
        usr_exp_t ue;
        dbg_exp_t de;
        for (int i = 0; i < NP; i++) begin
            if (bus.usr_gnt[i] === 1'b1) begin
                ue.port = i;
                ue.data = ram[bus.usr_addr[i*AW +: AW]];
                ue.due  = cyc + 2;
                usr_q.push_back(ue);
            end
        end
        if (bus.usr_valid != '0) begin
            if (usr_q.size() == 0) begin
                chk("usr_valid_unexpected", 64'(bus.usr_valid), 64'h0);
            end else begin
                ue = usr_q.pop_front();
                chk("usr_valid_port", 64'(bus.usr_valid), 64'(1 << ue.port));
                chk("usr_rdata", 64'(bus.usr_rdata[ue.port*DW +: DW]), 64'(ue.data));
                chk("usr_latency", 64'(cyc), 64'(ue.due));
            end
        end
        if (bus.dbg_ack === 1'b1) begin
            if (dbg_q.size() == 0) begin
                chk("dbg_ack_unexpected", 64'(bus.dbg_ack), 64'h0);
            end else begin
                de = dbg_q.pop_front();
                chk("dbg_ack_latency", 64'(cyc), 64'(de.due));
                if (de.rd) chk("dbg_rdata", 64'(bus.dbg_rdata), 64'(de.data));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst             = 1'b1;
        bus.dbg_en      = 1'b0;
        bus.dbg_req     = 1'b0;
        bus.dbg_we      = 1'b0;
        bus.dbg_load    = 1'b0;
        bus.dbg_autoinc = 1'b0;
        bus.dbg_addr    = '0;
        bus.dbg_wdata   = '0;
        bus.dbg_be      = '0;
        bus.usr_req     = 2'b11;
        bus.usr_addr    = {10'd9, 10'd5};

        tick(3);
        @(negedge clk);
        chk("rst_cpu_rst_n", 64'(bus.cpu_rst_n), 64'h0);
        chk("rst_dbg_mode",  64'(bus.dbg_mode), 64'h0);
        chk("rst_usr_gnt",   64'(bus.usr_gnt), 64'h0);
        chk("rst_mem_en",    64'(bus.mem_en), 64'h0);
        chk("rst_dbg_ack",   64'(bus.dbg_ack), 64'h0);
        chk("rst_overrun",   64'(bus.dbg_overrun), 64'h0);
        chk("rst_usr_valid", 64'(bus.usr_valid), 64'h0);

        tick(1);
        rst         = 1'b0;
        bus.usr_req = 2'b00;
        tick(2);
        @(negedge clk);
        chk("run_cpu_rst_n", 64'(bus.cpu_rst_n), 64'h1);
        chk("run_dbg_mode",  64'(bus.dbg_mode), 64'h0);

        // Round-robin between both ports, then dbg_en rises on a port-0 grant
        tick(1);
        bus.usr_req = 2'b11;
        for (int k = 0; k < 7; k++) begin
            if (k == 6) bus.dbg_en = 1'b1;
            @(negedge clk);
            chk("usr_gnt_rr", 64'(bus.usr_gnt), (k % 2 == 0) ? 64'h1 : 64'h2);
            tick(1);
        end
        @(negedge clk);
        chk("drain_usr_gnt",   64'(bus.usr_gnt), 64'h0);
        chk("drain_dbg_mode",  64'(bus.dbg_mode), 64'h1);
        chk("drain_cpu_rst_n", 64'(bus.cpu_rst_n), 64'h0);
        bus.usr_req = 2'b00;
        tick(3);
        chk("usr_rdata_hold", 64'(bus.usr_rdata), {VAL_B, VAL_A});

        // Bulk load across the top of the address space
        dbg_go(1'b1, 1'b1, 1'b1, 10'h3FE, 32'hC0DE_0000, 4'hF, 32'h0, 1'b1); tick(2);
        dbg_go(1'b1, 1'b0, 1'b1, 10'h155, 32'hC0DE_0001, 4'hF, 32'h0, 1'b1); tick(2);
        dbg_go(1'b1, 1'b0, 1'b1, 10'h155, 32'hC0DE_0002, 4'hF, 32'h0, 1'b1); tick(2);
        chk("ram_3fe", 64'(ram[10'h3FE]), 64'hC0DE_0000);
        chk("ram_3ff", 64'(ram[10'h3FF]), 64'hC0DE_0001);
        chk("ram_000", 64'(ram[10'h000]), 64'hC0DE_0002);
        // Pointer should now sit at 1
        dbg_go(1'b0, 1'b0, 1'b1, 10'h155, 32'h0, 4'h0, 32'h0000_1111, 1'b1); tick(3);

        dbg_go(1'b1, 1'b0, 1'b0, 10'h020, 32'hAABB_CCDD, 4'b0010, 32'h0, 1'b1); tick(2);
        chk("ram_be_0010", 64'(ram[10'h020]), 64'h1122_CC44);
        dbg_go(1'b1, 1'b0, 1'b0, 10'h020, 32'hFFFF_FFFF, 4'b0000, 32'h0, 1'b1); tick(2);
        chk("ram_be_0000", 64'(ram[10'h020]), 64'h1122_CC44);
        @(negedge clk);
        chk("overrun_clear", 64'(bus.dbg_overrun), 64'h0);

        // Read with a second strobe landing while the first is busy
        tick(1);
        dbg_go(1'b0, 1'b0, 1'b0, 10'd7, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b1);
        dbg_go(1'b0, 1'b0, 1'b0, 10'd5, 32'h0, 4'h0, 32'h0, 1'b0);
        tick(3);
        @(negedge clk);
        chk("overrun_set",     64'(bus.dbg_overrun), 64'h1);
        chk("dbg_rdata_hold",  64'(bus.dbg_rdata), 64'hDEAD_BEEF);

        // Leave debug mode while a read is in flight
        tick(1);
        dbg_go(1'b0, 1'b0, 1'b0, 10'd9, 32'h0, 4'h0, VAL_B, 1'b1);
        bus.dbg_en = 1'b0;
        tick(2);
        @(negedge clk);
        chk("exit_wait_dbg_mode", 64'(bus.dbg_mode), 64'h1);
        tick(1);
        @(negedge clk);
        chk("exit_dbg_mode",  64'(bus.dbg_mode), 64'h0);
        chk("exit_cpu_rst_n", 64'(bus.cpu_rst_n), 64'h1);

        // Re-enter debug and abort a write with rst
        bus.dbg_en = 1'b1;
        tick(4);
        dbg_go(1'b1, 1'b0, 1'b0, 10'h030, 32'h1234_5678, 4'hF, 32'h0, 1'b0);
        rst        = 1'b1;
        bus.dbg_en = 1'b0;
        @(negedge clk);
        chk("abort_mem_en", 64'(bus.mem_en), 64'h0);
        tick(1);
        @(negedge clk);
        chk("abort_dbg_ack",   64'(bus.dbg_ack), 64'h0);
        chk("abort_dbg_mode",  64'(bus.dbg_mode), 64'h0);
        chk("abort_cpu_rst_n", 64'(bus.cpu_rst_n), 64'h0);
        chk("abort_overrun",   64'(bus.dbg_overrun), 64'h0);
        chk("abort_dbg_rdata", 64'(bus.dbg_rdata), 64'h0);
        chk("abort_usr_rdata", 64'(bus.usr_rdata), 64'h0);
        chk("abort_ram",       64'(ram[10'h030]), 64'h5555_5555);
        tick(1);
        rst = 1'b0;
        tick(3);
        @(negedge clk);
        chk("post_rst_cpu_rst_n", 64'(bus.cpu_rst_n), 64'h1);
        chk("post_rst_dbg_ack",   64'(bus.dbg_ack), 64'h0);
        tick(2);
        chk("usr_q_drained", 64'(usr_q.size()), 64'h0);
        chk("dbg_q_drained", 64'(dbg_q.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/prog_mem_ctrl.md
Name: prog_mem_ctrl

Overview:
Multi-port memory controller for the on-chip program RAM, generalising the single-client programming controller. Arbitrates round-robin between NUM_PORTS user read ports and one debug/programming port driven by the JTAG path. In debug mode, user ports are locked out and the CPU is held in reset. Adds byte-enable writes, an auto-increment address pointer for bulk loads, and an overrun flag.

Parameters:
MEM_ADDR_WIDTH, 10, word address width (RAM depth 2^MEM_ADDR_WIDTH)
MEM_DATA_WIDTH, 32, word width; multiple of 8
NUM_PORTS, 2, number of user read ports, 1..8

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
dbg_en  in  1  level; requests debug mode (already synchronised to clk)
dbg_req  in  1  single-cycle access strobe (already synchronised)
dbg_we  in  1  1 = write, 0 = read
dbg_load  in  1  with dbg_req: load pointer from dbg_addr before access
dbg_autoinc  in  1  with dbg_req: use pointer as address, post-increment
dbg_addr  in  MEM_ADDR_WIDTH  direct access address
dbg_wdata  in  MEM_DATA_WIDTH  write data
dbg_be  in  MEM_DATA_WIDTH/8  write byte enables
dbg_rdata  out  MEM_DATA_WIDTH  read data, valid with dbg_ack
dbg_ack  out  1  single-cycle completion pulse
dbg_overrun  out  1  sticky; dbg_req was dropped
dbg_mode  out  1  controller is in debug mode
cpu_rst_n  out  1  CPU reset, low while in debug mode or in rst
usr_req  in  NUM_PORTS  per-port read request (level)
usr_addr  in  NUM_PORTS*MEM_ADDR_WIDTH  packed addresses; port i at [i*AW +: AW]
usr_gnt  out  NUM_PORTS  one-hot grant, combinational
usr_valid  out  NUM_PORTS  read data valid pulse
usr_rdata  out  NUM_PORTS*MEM_DATA_WIDTH  packed per-port read data, held
mem_en  out  1  RAM enable
mem_we  out  1  RAM write
mem_be  out  MEM_DATA_WIDTH/8  RAM byte enables
mem_addr  out  MEM_ADDR_WIDTH  RAM address
mem_wdata  out  MEM_DATA_WIDTH  RAM write data
mem_rdata  in  MEM_DATA_WIDTH  RAM read data, 1-cycle latency

Behaviour:
- Reset: FSM=NORMAL, pointer=0, RR priority=port 0, all outputs 0 (cpu_rst_n=0). cpu_rst_n goes to 1 in the first cycle after rst falls if dbg_en=0. rst mid-operation drops in-flight accesses with no ack or valid.
- FSM states: NORMAL, DRAIN, DBG_IDLE, DBG_WR, DBG_RD, DBG_RDW.
- NORMAL:
  - At most one grant per cycle, round-robin starting after the last granted port.
  - usr_gnt[i] is asserted combinationally in cycle T. mem_en=1 and mem_addr=usr_addr[i] are driven in cycle T.
  - In T+1, mem_rdata is registered into usr_rdata[i]. usr_valid[i] is 1 in T+2 only.
  - usr_rdata[i] holds its value until the next valid for port i.
- dbg_en=1 in NORMAL: go to DRAIN. No new grants. Wait 2 cycles so the last read completes, then go to DBG_IDLE.
- Debug mode (DRAIN and all DBG_* states):
  - dbg_mode=1, cpu_rst_n=0, usr_gnt=0.
- DBG_IDLE, dbg_req=1:
  - Address = dbg_autoinc ? (dbg_load ? dbg_addr : pointer) : dbg_addr.
  - If dbg_load=1, the pointer takes dbg_addr.
  - If dbg_autoinc=1, the pointer takes address+1. It wraps from 2^AW-1 to 0.
- DBG_WR (1 cycle):
  - mem_en=1; mem_be=dbg_be (captured); mem_wdata captured.
  - mem_we=1 only if be!=0. With be=0, no RAM write occurs but the ack is still given.
  - dbg_ack=1 in the next cycle (accept+2), then back to DBG_IDLE.
- DBG_RD / DBG_RDW:
  - DBG_RD drives mem_en=1 and mem_we=0; DBG_RDW waits one cycle.
  - dbg_rdata is registered from mem_rdata; dbg_ack=1 at accept+3.
  - dbg_rdata holds until the next read ack.
- dbg_req outside DBG_IDLE is dropped (no ack) and sets dbg_overrun. This covers debug-busy states, NORMAL, DRAIN, and dbg_req in the same cycle dbg_en rises. dbg_overrun clears only on rst.
- dbg_en=0:
  - Leave debug mode only from DBG_IDLE. An in-flight debug access completes and acks first.
  - Return to NORMAL; cpu_rst_n=1 and dbg_mode=0 from the next cycle.
- Simultaneous dbg_en rise and usr_req: in that cycle, grants follow the NORMAL rules; DRAIN then covers the granted read.
- Width rule: usr_rdata and usr_addr slices are indexed i*W +: W.

Test Plan:
- Reset, dbg_en=0, usr_req=2'b11 held, addresses 5 and 9 with RAM[5]=A, RAM[9]=B -> grants alternate 01,10,01…; each port gets valid 2 cycles after its grant with the correct data.
- dbg_en=1 with port 0 granted the same cycle -> port 0 valid arrives; usr_gnt then 0, cpu_rst_n=0, dbg_mode=1 after 2-cycle drain.
- Debug load+autoinc writes at 0x3FE, 3 words (AW=10) -> RAM[0x3FE], [0x3FF], [0x000] written; pointer=0x001; each ack 2 cycles after req.
- Write with dbg_be=4'b0010, wdata=0xAABBCCDD over 0x11223344 -> RAM=0x1122CC44; be=0 write -> RAM unchanged, ack still pulses.
- Read of addr 7 (RAM=0xDEADBEEF) -> dbg_ack at accept+3 with dbg_rdata=0xDEADBEEF; second dbg_req during the read -> dropped, dbg_overrun=1, single ack.
- dbg_en=0 mid-read, then rst asserted mid-write -> read acks before NORMAL resumes; after rst all outputs 0 and no ack for the aborted write.
